// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned READ_LATENCY_MAX = 3;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_state_t;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_arb_rd_tag_pipe.sv
// Read tag shift register: delays {valid, owner} of each accepted read by DEPTH cycles.
module mem_arb_rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    clr_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] tag_q;
  rd_tag_t [DEPTH-1:0] tag_d;

  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = tag_in;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Clearing drops every in-flight read so no stale rvalid follows a reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_out = tag_q[DEPTH-1];

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing the virtual memory bus between the CPU data port (m0) and loader/DMA (m1).
// Optional ownership locking for atomic sequences is enabled with MEM_ARB_LOCK_EN.
module memory_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata
);

  logic    last_gnt_q, last_gnt_d;
  logic    allow0_c, allow1_c;
  logic    gnt0_c, gnt1_c;
  rd_tag_t tag_in_c, tag_out;

`ifdef MEM_ARB_LOCK_EN
  lock_state_t lock_q, lock_d;
  lock_state_t free_next_c;

  // Owner keeps the bus only while it still holds its lock this cycle.
  always_comb begin
    allow0_c = !((lock_q == OWN1) && m1_lock);
    allow1_c = !((lock_q == OWN0) && m0_lock);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= FREE;
    end else begin
      lock_q <= lock_d;
    end
  end

  always_comb begin
    lock_d      = lock_q;
    free_next_c = FREE;
    if (gnt0_c && m0_lock) begin
      free_next_c = OWN0;
    end else if (gnt1_c && m1_lock) begin
      free_next_c = OWN1;
    end
    case (lock_q)
      FREE:    lock_d = free_next_c;
      OWN0:    lock_d = m0_lock ? OWN0 : free_next_c;
      OWN1:    lock_d = m1_lock ? OWN1 : free_next_c;
      default: lock_d = FREE;
    endcase
  end
`else
  always_comb begin
    allow0_c = 1'b1;
    allow1_c = 1'b1;
  end
`endif

  // Contention goes to whichever master did not win last; reset forces both grants low.
  always_comb begin
    gnt0_c = reset && m0_req && allow0_c &&
             (!(m1_req && allow1_c) || (last_gnt_q == MASTER1));
    gnt1_c = reset && m1_req && allow1_c && !gnt0_c;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0_c) begin
      last_gnt_d = MASTER0;
    end else if (gnt1_c) begin
      last_gnt_d = MASTER1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_q <= MASTER1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    if (gnt0_c) begin
      bus_addr  = m0_addr;
      bus_wdata = m0_wdata;
      bus_we    = m0_we;
    end else if (gnt1_c) begin
      bus_addr  = m1_addr;
      bus_wdata = m1_wdata;
      bus_we    = m1_we;
    end
  end

  always_comb begin
    tag_in_c.valid = (gnt0_c && !m0_we) || (gnt1_c && !m1_we);
    tag_in_c.owner = gnt1_c ? MASTER1 : MASTER0;
  end

  mem_arb_rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .clr_n   (reset),
    .tag_in  (tag_in_c),
    .tag_out (tag_out)
  );

  assign m0_gnt    = gnt0_c;
  assign m1_gnt    = gnt1_c;
  assign m0_rvalid = tag_out.valid && (tag_out.owner == MASTER0);
  assign m1_rvalid = tag_out.valid && (tag_out.owner == MASTER1);
  assign m0_rdata  = bus_rdata;
  assign m1_rdata  = bus_rdata;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter with a simple BRAM model behind the bus.
module tb_memory_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
`ifdef MEM_ARB_LOCK_EN
  logic          m0_lock, m1_lock;
`endif
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we;
  logic [DW-1:0] bus_rdata;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RL];

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_bus_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
`endif
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata)
  );

  // BRAM model: word addressed, read data RL cycles after the address.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bus_addr[9:2]];
    for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bus_we) mem[bus_addr[9:2]] <= bus_wdata;
  end
  assign bus_rdata = rd_pipe[RL-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest expected read for that master.
  always @(negedge clk) begin
    if (m0_rvalid === 1'b1) begin
      if (q0.size() == 0) check("m0_unexpected_rvalid", 64'(1), 64'(0));
      else check("m0_rdata", 64'(m0_rdata), 64'(q0.pop_front()));
    end
    if (m1_rvalid === 1'b1) begin
      if (q1.size() == 0) check("m1_unexpected_rvalid", 64'(1), 64'(0));
      else check("m1_rdata", 64'(m1_rdata), 64'(q1.pop_front()));
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int i0, i1;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    for (int i = 0; i < int'(RL); i++) rd_pipe[i] = '0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif

    // Reset with both masters requesting writes: nothing may be granted.
    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h1111_1111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4; m1_wdata = 32'h2222_2222;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m0_gnt", 64'(m0_gnt), 64'(0));
    check("rst_m1_gnt", 64'(m1_gnt), 64'(0));
    check("rst_m0_rvalid", 64'(m0_rvalid), 64'(0));
    check("rst_m1_rvalid", 64'(m1_rvalid), 64'(0));
    check("rst_bus_we", 64'(bus_we), 64'(0));
    #1;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    reset = 1'b1;

    // Contention: 4 reads each, grants must alternate starting with m0.
    i0 = 0; i1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      m0_req = (i0 < 4); m0_we = 1'b0; m0_addr = 32'(i0 * 4);
      m1_req = (i1 < 4); m1_we = 1'b0; m1_addr = 32'(32 + i1 * 4);
      @(negedge clk);
      check($sformatf("contend_m0_gnt_c%0d", c), 64'(m0_gnt), 64'((c % 2) == 0));
      check($sformatf("contend_m1_gnt_c%0d", c), 64'(m1_gnt), 64'((c % 2) == 1));
      if (m0_gnt) begin q0.push_back(32'hC0DE_0000 + 32'(i0)); i0++; end
      if (m1_gnt) begin q1.push_back(32'hC0DE_0000 + 32'(8 + i1)); i1++; end
    end
    idle();
    repeat (3) idle();

    // Single master: write then read the same word with no bubble.
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_m1_gnt", 64'(m1_gnt), 64'(1));
    check("wr_bus_we", 64'(bus_we), 64'(1));
    check("wr_bus_addr", 64'(bus_addr), 64'(32'h10));
    check("wr_bus_wdata", 64'(bus_wdata), 64'(32'hDEAD_BEEF));
    @(posedge clk); #1;
    m1_we = 1'b0;
    @(negedge clk);
    check("rd_m1_gnt", 64'(m1_gnt), 64'(1));
    check("rd_bus_we", 64'(bus_we), 64'(0));
    check("rd_m0_gnt", 64'(m0_gnt), 64'(0));
    if (m1_gnt) q1.push_back(32'hDEAD_BEEF);
    repeat (4) idle();

    // Reset while a read is in flight: its response must never appear.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    @(negedge clk);
    check("flight_m0_gnt", 64'(m0_gnt), 64'(1));
    #1;
    reset = 1'b0;
    m0_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("flight_rst_rvalid", 64'(m0_rvalid), 64'(0));
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("flight_post_rvalid_%0d", c), 64'(m0_rvalid), 64'(0));
    end

`ifdef MEM_ARB_LOCK_EN
    // Lock: m1 owns the bus for 3 transfers while m0 keeps requesting.
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1;
    @(negedge clk);
    check("lock_pre_m0_gnt", 64'(m0_gnt), 64'(1));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      m0_addr = 32'h44; m0_wdata = 32'h2;
      m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
      m1_addr = 32'(32'h80 + k * 4); m1_wdata = 32'(k);
      @(negedge clk);
      check($sformatf("lock_m1_gnt_%0d", k), 64'(m1_gnt), 64'(1));
      check($sformatf("lock_m0_gnt_%0d", k), 64'(m0_gnt), 64'(0));
    end
    @(posedge clk); #1;
    m1_lock = 1'b0;
    @(negedge clk);
    check("unlock_m0_gnt", 64'(m0_gnt), 64'(1));
    check("unlock_m1_gnt", 64'(m1_gnt), 64'(0));
`endif

    repeat (5) idle();
    @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'(0));
    check("q1_drained", 64'(q1.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
